// File: rtl/i2c_pkg.sv
// Shared command codes, phase constants and the per-phase open-drain drive table
// for the I2C bit-level sequencer.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMD  = 1'b1
  } state_t;

  localparam int         NUM_PHASES = 4;
  localparam logic [1:0] PH_LAST    = 2'(NUM_PHASES - 1);
  localparam logic [1:0] PH_STRETCH = 2'd1;
  localparam logic [1:0] PH_SAMPLE  = 2'd2;

  // Returns {sda_oe, scl_oe}; an enable of 1 pulls the line low.
  function automatic logic [1:0] phase_oe(input cmd_t cmd, input logic [1:0] ph, input logic d);
    logic [1:0] oe;
    oe = 2'b00;
    case (cmd)
      CMD_START: begin
        case (ph)
          2'd0, 2'd1: oe = 2'b00;
          2'd2:       oe = 2'b10;
          default:    oe = 2'b11;
        endcase
      end
      CMD_STOP: begin
        case (ph)
          2'd0:       oe = 2'b11;
          2'd1, 2'd2: oe = 2'b10;
          default:    oe = 2'b00;
        endcase
      end
      CMD_WRITE: oe = {~d, (ph == 2'd0) || (ph == 2'd3)};
      default:   oe = {1'b0, (ph == 2'd0) || (ph == 2'd3)};
    endcase
    return oe;
  endfunction

endpackage

// File: rtl/i2c_bit_ctrl_if.sv
// Command handshake, status and pad signals of the I2C bit sequencer.
// The slave modport is the sequencer, master is the byte controller plus pads.
interface i2c_bit_ctrl_if #(
  parameter int PRESC_W = 16
);
  logic [PRESC_W-1:0] prescale;
  logic [1:0]         cmd;
  logic               cmd_wdata;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               done;
  logic               rd_bit;
  logic               arb_lost;
  logic               busy;
  logic               scl_i;
  logic               sda_i;
  logic               scl_oe;
  logic               sda_oe;

  modport slave (
    input  prescale, cmd, cmd_wdata, cmd_valid, scl_i, sda_i,
    output cmd_ready, done, rd_bit, arb_lost, busy, scl_oe, sda_oe
  );

  modport master (
    output prescale, cmd, cmd_wdata, cmd_valid, scl_i, sda_i,
    input  cmd_ready, done, rd_bit, arb_lost, busy, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_sync.sv
// Two-flop synchronizer for an asynchronous pad input; resets to 1 (idle bus level).
module i2c_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master: runs one START/STOP/WRITE/READ command as four prescaled
// phases, driving registered SCL/SDA open-drain enables.
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  i2c_bit_ctrl_if.slave  bus
);

  state_t             r_state, w_state_next;
  cmd_t               r_cmd, w_cmd_next;
  logic               r_wdata, w_wdata_next;
  logic [PRESC_W-1:0] r_presc, w_presc_next;
  logic [PRESC_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]         r_ph, w_ph_next;
  logic               r_scl_oe, w_scl_oe_next;
  logic               r_sda_oe, w_sda_oe_next;
  logic               r_done, w_done_next;
  logic               r_arb_lost, w_arb_lost_next;
  logic               r_rd_bit, w_rd_bit_next;
  logic               w_scl_s;
  logic               w_sda_s;
  logic               w_lost;

  i2c_sync u_scl_sync (.clk(clk), .rst_n(rst_n), .i_d(bus.scl_i), .o_q(w_scl_s));
  i2c_sync u_sda_sync (.clk(clk), .rst_n(rst_n), .i_d(bus.sda_i), .o_q(w_sda_s));

  // We released SDA to send a 1 but someone else holds it low.
  assign w_lost = (r_cmd == CMD_WRITE) && r_wdata && !w_sda_s && (r_ph == PH_SAMPLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cmd      <= CMD_START;
      r_wdata    <= 1'b0;
      r_presc    <= '0;
      r_cnt      <= '0;
      r_ph       <= 2'd0;
      r_scl_oe   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_done     <= 1'b0;
      r_arb_lost <= 1'b0;
      r_rd_bit   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cmd      <= w_cmd_next;
      r_wdata    <= w_wdata_next;
      r_presc    <= w_presc_next;
      r_cnt      <= w_cnt_next;
      r_ph       <= w_ph_next;
      r_scl_oe   <= w_scl_oe_next;
      r_sda_oe   <= w_sda_oe_next;
      r_done     <= w_done_next;
      r_arb_lost <= w_arb_lost_next;
      r_rd_bit   <= w_rd_bit_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cmd_next      = r_cmd;
    w_wdata_next    = r_wdata;
    w_presc_next    = r_presc;
    w_cnt_next      = r_cnt;
    w_ph_next       = r_ph;
    w_scl_oe_next   = r_scl_oe;
    w_sda_oe_next   = r_sda_oe;
    w_done_next     = 1'b0;
    w_arb_lost_next = 1'b0;
    w_rd_bit_next   = r_rd_bit;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_next                   = ST_CMD;
          w_cmd_next                     = cmd_t'(bus.cmd);
          w_wdata_next                   = bus.cmd_wdata;
          w_presc_next                   = bus.prescale;
          w_cnt_next                     = bus.prescale;
          w_ph_next                      = 2'd0;
          {w_sda_oe_next, w_scl_oe_next} = phase_oe(cmd_t'(bus.cmd), 2'd0, bus.cmd_wdata);
        end
      end
      ST_CMD: begin
        // A slave holding SCL low freezes the high phase until it lets go.
        if ((r_ph == PH_STRETCH) && !w_scl_s) begin
          w_cnt_next = r_cnt;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_cnt_next = r_presc;
          if ((r_ph == PH_SAMPLE) && (r_cmd == CMD_READ))
            w_rd_bit_next = w_sda_s;
          if (w_lost) begin
            w_arb_lost_next = 1'b1;
            w_state_next    = ST_IDLE;
            w_scl_oe_next   = 1'b0;
            w_sda_oe_next   = 1'b0;
          end else if (r_ph == PH_LAST) begin
            w_done_next  = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_ph_next                      = r_ph + 2'd1;
            {w_sda_oe_next, w_scl_oe_next} = phase_oe(r_cmd, r_ph + 2'd1, r_wdata);
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.arb_lost  = r_arb_lost;
  assign bus.rd_bit    = r_rd_bit;
  assign bus.scl_oe    = r_scl_oe;
  assign bus.sda_oe    = r_sda_oe;

endmodule
